// File: rtl/pu_operand_feeder.sv
// FIFO-buffered FP16 operand-pair issuer for processing_unit, with a stuck-unit timeout.
// Defining PU_FEEDER_ZERO_SKIP_EN drops pairs with a +/-0 operand instead of issuing them.
module pu_operand_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_a,
    input  logic [15:0]                in_b,
    output logic                       pu_en,
    output logic [15:0]                pu_a,
    output logic [15:0]                pu_b,
    input  logic                       pu_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       timeout_err,
    output logic                       skipped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pu_en_q, pu_en_d;
    logic [15:0]      pu_a_q, pu_a_d;
    logic [15:0]      pu_b_q, pu_b_d;
    logic             timeout_err_q, timeout_err_d;
    logic [31:0]      head;
    logic             push, pop, skip_head;

    // Upstream handshake: a pair transfers on a cycle where in_valid && in_ready;
    // in_ready depends only on the registered occupancy, never on in_valid or a same-cycle pop.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

`ifdef PU_FEEDER_ZERO_SKIP_EN
    logic skipped_q, skipped_d;

    assign skip_head = (head[30:16] == 15'd0) || (head[14:0] == 15'd0);
    assign skipped_d = (state_q == ST_IDLE) && (count_q != '0) && skip_head;

    always_ff @(posedge clk) begin
        if (reset) skipped_q <= 1'b0;
        else       skipped_q <= skipped_d;
    end

    assign skipped = skipped_q;
`else
    assign skip_head = 1'b0;
    assign skipped   = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        pu_en_d       = pu_en_q;
        pu_a_d        = pu_a_q;
        pu_b_d        = pu_b_q;
        timeout_err_d = 1'b0;
        pop           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (!skip_head) begin
                        pu_a_d  = head[31:16];
                        pu_b_d  = head[15:0];
                        pu_en_d = 1'b1;
                        timer_d = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // ready takes precedence over an expiring timer on the same cycle
                if (pu_ready) begin
                    pu_en_d = 1'b0;
                    state_d = ST_GAP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    pu_en_d       = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_GAP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                pu_en_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            pu_en_q       <= 1'b0;
            pu_a_q        <= '0;
            pu_b_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            pu_en_q       <= pu_en_d;
            pu_a_q        <= pu_a_d;
            pu_b_q        <= pu_b_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
    end

    assign pu_en       = pu_en_q;
    assign pu_a        = pu_a_q;
    assign pu_b        = pu_b_q;
    assign count       = count_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_pu_operand_feeder.sv
// Bench for pu_operand_feeder: directed scenarios plus random traffic, all checked each cycle
// against a queue-based model of the feeder; honours PU_FEEDER_ZERO_SKIP_EN when defined.
module tb_pu_operand_feeder;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = $clog2(DEPTH + 1);
`ifdef PU_FEEDER_ZERO_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    // clock / reset and DUT
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_a = '0;
    logic [15:0]      in_b = '0;
    logic             pu_en;
    logic [15:0]      pu_a;
    logic [15:0]      pu_b;
    logic             pu_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             timeout_err;
    logic             skipped;

    always #5 clk = ~clk;

    pu_operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .pu_en(pu_en), .pu_a(pu_a), .pu_b(pu_b),
        .pu_ready(pu_ready), .busy(busy), .count(count),
        .timeout_err(timeout_err), .skipped(skipped)
    );

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog: simulation did not reach its summary");
    end

    // scoreboard / reference model
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          to_pulses = 0;
    logic        prev_en = 1'b0;
    logic [31:0] exp_q[$];        // pairs accepted but not yet taken by the unit
    bit          m_issuing = 0;   // a pair is presented to the unit
    bit          m_in_gap = 0;
    int          m_left = 0;      // cycles the unit still has before timeout
    logic        m_en = 1'b0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic        m_to = 1'b0;
    logic        m_sk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit has_zero(input logic [31:0] p);
        return (p[30:16] == 15'd0) || (p[14:0] == 15'd0);
    endfunction

    // Advance the model by one clock from the current inputs, clock the DUT, compare everything.
    task automatic step();
        int          occ;
        bit          accept;
        logic [31:0] head;
        occ    = exp_q.size();
        accept = in_valid && (occ != DEPTH);
        m_to   = 1'b0;
        m_sk   = 1'b0;
        if (reset) begin
            exp_q.delete();
            m_issuing = 0;
            m_in_gap  = 0;
            m_en      = 1'b0;
            m_a       = '0;
            m_b       = '0;
        end else begin
            if (m_in_gap) begin
                m_in_gap = 0;
            end else if (m_issuing) begin
                m_left--;
                if (pu_ready || m_left == 0) begin
                    m_to      = !pu_ready;
                    m_issuing = 0;
                    m_in_gap  = 1;
                    m_en      = 1'b0;
                end
            end else if (occ != 0) begin
                head = exp_q.pop_front();
                if (SKIP_EN && has_zero(head)) begin
                    m_sk = 1'b1;
                end else begin
                    m_a       = head[31:16];
                    m_b       = head[15:0];
                    m_en      = 1'b1;
                    m_issuing = 1;
                    m_left    = TIMEOUT;
                end
            end
            if (accept) exp_q.push_back({in_a, in_b});
        end
        prev_en = pu_en;
        @(posedge clk);
        #1;
        cyc++;
        if (pu_en === 1'b1 && prev_en !== 1'b1) rise_cyc = cyc;
        check("pu_en", 32'(pu_en), 32'(m_en));
        check("pu_a", 32'(pu_a), 32'(m_a));
        check("pu_b", 32'(pu_b), 32'(m_b));
        check("count", 32'(count), 32'(exp_q.size()));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
        check("busy", 32'(busy), 32'(m_issuing || m_in_gap || exp_q.size() != 0));
        check("timeout_err", 32'(timeout_err), 32'(m_to));
        check("skipped", 32'(skipped), 32'(m_sk));
    endtask

    task automatic drive_pair(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        // 1: reset, single pair, ready four cycles after issue
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("t1_reset_busy", 32'(busy), 32'd0);
        drive_pair(16'h4400, 16'h4600);
        step();
        in_valid = 1'b0;
        check("t1_count_after_push", 32'(count), 32'd1);
        check("t1_en_before_issue", 32'(pu_en), 32'd0);
        step();
        check("t1_en_latency", 32'(pu_en), 32'd1);
        check("t1_issue_a", 32'(pu_a), 32'h4400);
        check("t1_issue_b", 32'(pu_b), 32'h4600);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_hold_a", 32'(pu_a), 32'h4400);
        end
        pu_ready = 1'b1;
        step();
        pu_ready = 1'b0;
        check("t1_en_after_ready", 32'(pu_en), 32'd0);
        check("t1_busy_in_gap", 32'(busy), 32'd1);
        step();
        check("t1_busy_idle", 32'(busy), 32'd0);

        // 2: back-to-back pairs, ordering and issue spacing
        drive_pair(16'h4400, 16'h4600);
        step();
        drive_pair(16'h4000, 16'hC400);
        step();
        in_valid = 1'b0;
        check("t2_first_a", 32'(pu_a), 32'h4400);
        check("t2_count_one", 32'(count), 32'd1);
        pu_ready = 1'b1;
        step();
        pu_ready = 1'b0;
        step();
        check("t2_gap_en", 32'(pu_en), 32'd0);
        step();
        check("t2_second_rise_spacing", 32'(pu_en), 32'd1);
        check("t2_second_a", 32'(pu_a), 32'h4000);
        check("t2_second_b", 32'(pu_b), 32'hC400);
        check("t2_count_zero", 32'(count), 32'd0);
        pu_ready = 1'b1;
        step();
        pu_ready = 1'b0;
        step();

        // 3: overfill with the unit stuck, then drain purely by timeouts
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == DEPTH) break;
            drive_pair(16'($urandom) | 16'h0400, 16'($urandom) | 16'h0400);
            step();
        end
        drive_pair(16'h1234, 16'h5678);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t3_full_in_ready", 32'(in_ready), 32'd0);
            check("t3_full_count", 32'(count), 32'(DEPTH));
        end
        in_valid  = 1'b0;
        to_pulses = 0;
        for (int i = 0; i < (DEPTH + 2) * (TIMEOUT + 3); i++) begin
            if (!busy) break;
            step();
            if (timeout_err === 1'b1) begin
                to_pulses++;
                check("t3_timeout_distance", 32'(cyc - rise_cyc), 32'(TIMEOUT));
            end
        end
        check("t3_timeout_pulses", 32'(to_pulses), 32'(DEPTH + 1));
        check("t3_drained", 32'(busy), 32'd0);

        // 4: reset in the middle of a wait with pairs still queued
        for (int i = 0; i < 4; i++) begin
            drive_pair(16'h3C00 + 16'(i), 16'h4200 + 16'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        check("t4_waiting", 32'(pu_en), 32'd1);
        check("t4_queued", 32'(count), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t4_reset_en", 32'(pu_en), 32'd0);
        check("t4_reset_count", 32'(count), 32'd0);
        check("t4_reset_a", 32'(pu_a), 32'd0);
        pu_ready = 1'b1;
        step();
        pu_ready = 1'b0;
        check("t4_late_ready_en", 32'(pu_en), 32'd0);
        check("t4_late_ready_busy", 32'(busy), 32'd0);

        // 5: ready on exactly the last allowed wait cycle
        drive_pair(16'h3C00, 16'h5000);
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        check("t5_still_waiting", 32'(pu_en), 32'd1);
        pu_ready = 1'b1;
        step();
        pu_ready = 1'b0;
        check("t5_no_timeout", 32'(timeout_err), 32'd0);
        check("t5_en_low", 32'(pu_en), 32'd0);
        step();
        check("t5_no_timeout_late", 32'(timeout_err), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);

        // 6: negative-zero operand followed by a normal pair
        drive_pair(16'h8000, 16'h4600);
        step();
        drive_pair(16'h4400, 16'h4600);
        step();
        in_valid = 1'b0;
`ifdef PU_FEEDER_ZERO_SKIP_EN
        check("t6_skip_pulse", 32'(skipped), 32'd1);
        check("t6_skip_no_en", 32'(pu_en), 32'd0);
        step();
        check("t6_skip_pulse_end", 32'(skipped), 32'd0);
        check("t6_second_issue", 32'(pu_a), 32'h4400);
        pu_ready = 1'b1;
        step();
        pu_ready = 1'b0;
        step();
`else
        check("t6_zero_issued", 32'(pu_a), 32'h8000);
        check("t6_no_skip", 32'(skipped), 32'd0);
        pu_ready = 1'b1;
        step();
        pu_ready = 1'b0;
        step();
        step();
        check("t6_second_issue", 32'(pu_a), 32'h4400);
        check("t6_no_skip_second", 32'(skipped), 32'd0);
        pu_ready = 1'b1;
        step();
        pu_ready = 1'b0;
        step();
`endif

        // random traffic, including occasional zero operands
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            in_b     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            pu_ready = ($urandom_range(0, 3) == 0);
            step();
        end
        in_valid = 1'b0;
        pu_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            step();
        end
        pu_ready = 1'b0;
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
